touch_led_array: RTL and testbench

TOUCH_LED_ARRAY -- requirements
Module: touch_led_array

---
 rtl/touch_led_pkg.sv | 28 ++
 rtl/touch_key_debounce.sv | 124 ++++++++++++
 rtl/touch_led_array.sv | 100 ++++++++++
 tb/tb_touch_led_array.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_led_pkg.sv
// touch_led_pkg: shared types for the touch-key / LED array.
//   key_state_e : per-channel debounce FSM state (2-bit encoding)
//   led_mode_e  : per-channel LED behaviour selected by the mode input
//   is_held()   : true while a key counts as held (accepted press, release
//                 not yet confirmed)
package touch_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_REL_CHK   = 2'd3
  } key_state_e;

  typedef enum logic {
    MODE_TOGGLE    = 1'b0,
    MODE_MOMENTARY = 1'b1
  } led_mode_e;

  // Untouched key level; the synchronizer resets to it so reset never
  // looks like a press.
  localparam logic KEY_RELEASED = 1'b1;

  function automatic logic is_held(key_state_e s);
    return (s == ST_PRESSED) || (s == ST_REL_CHK);
  endfunction

endpackage

// File: rtl/touch_key_debounce.sv
// touch_key_debounce: one touch-key channel.
//   2-flop synchronizer -> 4-state debounce FSM with saturating counter.
//   Optional long-press detector when TOUCH_LONG_PRESS_EN is defined.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   key_in           : raw asynchronous key level, 0 = touched
//   press_pulse      : registered one-cycle accepted-press strobe
//   press_nxt        : value press_pulse takes on the coming edge
//   held_nxt         : coming-edge state is PRESSED or REL_CHK
//   long_nxt         : (TOUCH_LONG_PRESS_EN) coming edge completes a
//                      LONG_CYC-cycle PRESSED dwell
module touch_key_debounce
  import touch_led_pkg::*;
#(
  parameter int DEB_CYC = 1_000_000
`ifdef TOUCH_LONG_PRESS_EN
  , parameter int LONG_CYC = 50_000_000
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic press_pulse,
  output logic press_nxt,
  output logic held_nxt
`ifdef TOUCH_LONG_PRESS_EN
  , output logic long_nxt
`endif
);

  localparam int CW = $clog2(DEB_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

  logic          sync1_q, sync2_q;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE:      if (!sync2_q) state_d = ST_PRESS_CHK;
      ST_PRESS_CHK: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_PRESSED;
          pulse_d = 1'b1;
        end
      end
      ST_PRESSED:   if (sync2_q) state_d = ST_REL_CHK;
      ST_REL_CHK: begin
        if (!sync2_q) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase

    // Counter runs only while a check state persists; any transition
    // clears it, and it never passes CNT_MAX.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == ST_PRESS_CHK) || (state_q == ST_REL_CHK)) &&
                 (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef TOUCH_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYC + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYC);

  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_d;

  // Counts edges spent in PRESSED; saturating one past the firing value
  // keeps a single pulse per dwell.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (state_q != ST_PRESSED) begin
      long_cnt_d = '0;
    end else if (long_cnt_q != LONG_SAT) begin
      long_cnt_d = long_cnt_q + 1'b1;
      long_d     = (long_cnt_q == LONG_LAST);
    end
  end

  assign long_nxt = long_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q    <= KEY_RELEASED;
      sync2_q    <= KEY_RELEASED;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
`ifdef TOUCH_LONG_PRESS_EN
      long_cnt_q <= '0;
`endif
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
`ifdef TOUCH_LONG_PRESS_EN
      long_cnt_q <= long_cnt_d;
`endif
    end
  end

  assign press_pulse = pulse_q;
  assign press_nxt   = pulse_d;
  assign held_nxt    = is_held(state_d);

endmodule

// File: rtl/touch_led_array.sv
// touch_led_array: CH_NUM independent debounced touch keys driving LEDs.
//   Per channel, mode=0 toggles the LED on each accepted press; mode=1
//   lights it while the key is held.
// Optional feature macro: TOUCH_LONG_PRESS_EN adds LONG_CYC and long_press;
//   a long press pulses long_press[i] and switches off all toggle LEDs.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   touch_key        : raw key levels, 0 = touched
//   mode             : per-channel mode, 0 = toggle, 1 = momentary
//   led              : registered LED drive (polarity per LED_ACTIVE_LOW)
//   press_pulse      : one-cycle accepted-press strobe per channel
//   long_press       : (TOUCH_LONG_PRESS_EN) one-cycle long-press strobe
module touch_led_array
  import touch_led_pkg::*;
#(
  parameter int CH_NUM         = 4,
  parameter int DEB_CYC        = 1_000_000,
`ifdef TOUCH_LONG_PRESS_EN
  parameter int LONG_CYC       = 50_000_000,
`endif
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CH_NUM-1:0] touch_key,
  input  logic [CH_NUM-1:0] mode,
  output logic [CH_NUM-1:0] led,
  output logic [CH_NUM-1:0] press_pulse
`ifdef TOUCH_LONG_PRESS_EN
  , output logic [CH_NUM-1:0] long_press
`endif
);

  localparam logic LED_ON  = (LED_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic LED_OFF = ~LED_ON;

  logic [CH_NUM-1:0] press_nxt;
  logic [CH_NUM-1:0] held_nxt;
  logic [CH_NUM-1:0] led_q, led_d;
`ifdef TOUCH_LONG_PRESS_EN
  logic [CH_NUM-1:0] long_nxt;
  logic [CH_NUM-1:0] long_q;
`endif

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    touch_key_debounce #(
      .DEB_CYC  (DEB_CYC)
`ifdef TOUCH_LONG_PRESS_EN
      , .LONG_CYC (LONG_CYC)
`endif
    ) u_deb (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (touch_key[g]),
      .press_pulse (press_pulse[g]),
      .press_nxt   (press_nxt[g]),
      .held_nxt    (held_nxt[g])
`ifdef TOUCH_LONG_PRESS_EN
      , .long_nxt  (long_nxt[g])
`endif
    );
  end

  // LEDs follow next-state values so they change on the same edge as the
  // pulse / FSM state they reflect.
  always_comb begin
    led_d = led_q;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (mode[i] == MODE_MOMENTARY) begin
        led_d[i] = held_nxt[i] ? LED_ON : LED_OFF;
      end else begin
        if (press_nxt[i]) led_d[i] = ~led_q[i];
`ifdef TOUCH_LONG_PRESS_EN
        // Long-press clear overrides a coincident toggle.
        if (|long_nxt) led_d[i] = LED_OFF;
`endif
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_q  <= {CH_NUM{LED_OFF}};
`ifdef TOUCH_LONG_PRESS_EN
      long_q <= '0;
`endif
    end else begin
      led_q  <= led_d;
`ifdef TOUCH_LONG_PRESS_EN
      long_q <= long_nxt;
`endif
    end
  end

  assign led = led_q;
`ifdef TOUCH_LONG_PRESS_EN
  assign long_press = long_q;
`endif

endmodule

// File: tb/tb_touch_led_array.sv
module tb_touch_led_array;

  localparam int CH   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 16;
`ifdef TOUCH_LONG_PRESS_EN
  localparam int OW = 12;
`else
  localparam int OW = 8;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [CH-1:0] touch_key, mode, led, press_pulse;
`ifdef TOUCH_LONG_PRESS_EN
  logic [CH-1:0] long_press;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a key is accepted when the synchronized level opposes
  // the accepted level for DEB+1 consecutive edges.
  logic [CH-1:0] m_s1, m_s2, m_pressed, m_led, m_pulse, m_long;
  int            m_run   [CH];
  int            m_dwell [CH];

  logic [OW-1:0] obs, expv;
`ifdef TOUCH_LONG_PRESS_EN
  assign obs  = {long_press, led, press_pulse};
  assign expv = {m_long, m_led, m_pulse};
`else
  assign obs  = {led, press_pulse};
  assign expv = {m_led, m_pulse};
`endif

  touch_led_array #(
    .CH_NUM         (CH),
    .DEB_CYC        (DEB),
`ifdef TOUCH_LONG_PRESS_EN
    .LONG_CYC       (LONG),
`endif
    .LED_ACTIVE_LOW (1)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .touch_key   (touch_key),
    .mode        (mode),
    .led         (led),
    .press_pulse (press_pulse)
`ifdef TOUCH_LONG_PRESS_EN
    , .long_press (long_press)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_step();
    logic [CH-1:0] syn;
    if (sys_rst) begin
      m_s1 = '1; m_s2 = '1; m_pressed = '0; m_led = '1; m_pulse = '0; m_long = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0; m_dwell[c] = 0;
      end
    end else begin
      syn = m_s2; m_pulse = '0; m_long = '0;
      for (int c = 0; c < CH; c++) begin
        if (m_pressed[c] && m_run[c] == 0) begin
          m_dwell[c]++;
          if (m_dwell[c] == LONG) m_long[c] = 1'b1;
        end else begin
          m_dwell[c] = 0;
        end
        if (syn[c] == m_pressed[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == DEB + 1) begin
          m_pressed[c] = ~m_pressed[c];
          m_run[c]     = 0;
          m_pulse[c]   = m_pressed[c];
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (mode[c]) m_led[c] = ~m_pressed[c];
        else if (m_pulse[c]) m_led[c] = ~m_led[c];
      end
`ifdef TOUCH_LONG_PRESS_EN
      if (|m_long)
        for (int c = 0; c < CH; c++) if (!mode[c]) m_led[c] = 1'b1;
`endif
      m_s2 = m_s1;
      m_s1 = touch_key;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1; touch_key = '1; mode = '0;
    tick(); tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; touch_key = '0; mode = '0;
    tick(); tick();
    n_vec++;
    if (led !== 4'hF) begin
      n_err++; $display("FAIL reset_led: got %b want 1111", led);
    end
    n_vec++;
    if (press_pulse !== 4'h0) begin
      n_err++; $display("FAIL reset_pulse: got %b want 0000", press_pulse);
    end
    touch_key = '1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int pulse_t = -1, n_pulse = 0;
    logic led_before = 1'bx, led_at = 1'bx;
    apply_reset();
    for (int i = 1; i <= 22; i++) begin
      touch_key[0] = (i <= 10) ? 1'b0 : 1'b1;
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL clean_press t=%0d: got %h want %h", i, obs, expv);
      end
      if (press_pulse[0]) begin n_pulse++; pulse_t = i; end
      if (i == 1 + DEB + 1) led_before = led[0];
      if (i == 1 + DEB + 2) led_at = led[0];
    end
    n_vec++;
    if (pulse_t != 1 + DEB + 2 || n_pulse != 1) begin
      n_err++; $display("FAIL clean_press_latency: got t=%0d n=%0d want t=%0d n=1", pulse_t, n_pulse, 1 + DEB + 2);
    end
    n_vec++;
    if (led_before !== 1'b1 || led_at !== 1'b0) begin
      n_err++; $display("FAIL clean_press_led: got %b->%b want 1->0", led_before, led_at);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int n_pulse = 0;
    apply_reset();
    pat = 8'b1000_1000; // bit i-1 = 1 -> high
    for (int i = 1; i <= 20; i++) begin
      touch_key[1] = (i <= 8) ? pat[i-1] : 1'b1;
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL bounce t=%0d: got %h want %h", i, obs, expv);
      end
      if (press_pulse[1]) n_pulse++;
      n_vec++;
      if (led[1] !== 1'b1) begin
        n_err++; $display("FAIL bounce_led t=%0d: got %b want 1", i, led[1]);
      end
    end
    n_vec++;
    if (n_pulse != 0) begin
      n_err++; $display("FAIL bounce_pulse: got %0d pulses want 0", n_pulse);
    end
  endtask

  task automatic test_momentary();
    logic want;
    apply_reset();
    mode = 4'b0100;
    for (int i = 1; i <= 35; i++) begin
      touch_key[2] = (i <= 20) ? 1'b0 : 1'b1;
      tick();
      want = (i >= 1 + DEB + 2 && i < 21 + DEB + 2) ? 1'b0 : 1'b1;
      n_vec++;
      if (led[2] !== want || obs !== expv) begin
        n_err++; $display("FAIL momentary t=%0d: led2 got %b want %b, outs got %h want %h", i, led[2], want, obs, expv);
      end
    end
  endtask

  task automatic test_simultaneous();
    int pulse_t = -1;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      touch_key[0] = (i <= 8) ? 1'b0 : 1'b1;
      touch_key[3] = (i <= 8) ? 1'b0 : 1'b1;
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL simultaneous t=%0d: got %h want %h", i, obs, expv);
      end
      if (press_pulse == 4'b1001) pulse_t = i;
    end
    n_vec++;
    if (pulse_t != 1 + DEB + 2 || led !== 4'b0110) begin
      n_err++; $display("FAIL simultaneous_result: got t=%0d led=%b want t=%0d led=0110", pulse_t, led, 1 + DEB + 2);
    end
  endtask

  task automatic test_reset_mid();
    int n_pulse = 0, pulse_t = -1;
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      sys_rst = (i == 5);
      if (i <= 4) touch_key[0] = 1'b0;
      else if (i <= 20) touch_key[0] = 1'b1;
      else touch_key[0] = (i <= 30) ? 1'b0 : 1'b1;
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL reset_mid t=%0d: got %h want %h", i, obs, expv);
      end
      if (i <= 20 && press_pulse != 0) n_pulse++;
      if (i == 20) begin
        n_vec++;
        if (led !== 4'hF) begin
          n_err++; $display("FAIL reset_mid_led: got %b want 1111", led);
        end
      end
      if (i > 20 && press_pulse[0]) pulse_t = i;
    end
    sys_rst = 1'b0;
    n_vec++;
    if (n_pulse != 0 || pulse_t != 21 + DEB + 2) begin
      n_err++; $display("FAIL reset_mid_pulse: got n=%0d t=%0d want n=0 t=%0d", n_pulse, pulse_t, 21 + DEB + 2);
    end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    mode = 4'b0100;
    for (int i = 1; i <= 30; i++) begin
      if (i == 10) mode[2] = 1'b0;
      touch_key[2] = (i <= 15) ? 1'b0 : 1'b1;
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL mode_switch t=%0d: got %h want %h", i, obs, expv);
      end
    end
    n_vec++;
    if (led[2] !== 1'b0) begin
      n_err++; $display("FAIL mode_switch_hold: got %b want 0", led[2]);
    end
    mode[2] = 1'b1;
    tick();
    n_vec++;
    if (led[2] !== 1'b1) begin
      n_err++; $display("FAIL mode_switch_momentary: got %b want 1", led[2]);
    end
  endtask

`ifdef TOUCH_LONG_PRESS_EN
  task automatic test_long_press();
    int n_long = 0, long_t = -1;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      touch_key[1:0] = (i <= 8) ? 2'b00 : 2'b11;
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL long_setup t=%0d: got %h want %h", i, obs, expv);
      end
    end
    n_vec++;
    if (led[1:0] !== 2'b00) begin
      n_err++; $display("FAIL long_setup_led: got %b want 00", led[1:0]);
    end
    for (int i = 1; i <= 40; i++) begin
      touch_key[2] = (i <= 25) ? 1'b0 : 1'b1;
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL long_press t=%0d: got %h want %h", i, obs, expv);
      end
      if (long_press != 0) begin
        n_long++;
        if (long_press == 4'b0100) long_t = i;
      end
    end
    n_vec++;
    if (n_long != 1 || long_t != 1 + DEB + 2 + LONG || led !== 4'hF) begin
      n_err++; $display("FAIL long_press_result: got n=%0d t=%0d led=%b want n=1 t=%0d led=1111",
                        n_long, long_t, led, 1 + DEB + 2 + LONG);
    end
  endtask
`endif

  task automatic test_random();
    int hold [CH];
    apply_reset();
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int i = 1; i <= 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          touch_key[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 10));
        end
        hold[c]--;
      end
      if ($urandom_range(0, 39) == 0) mode = 4'($urandom);
      sys_rst = ($urandom_range(0, 299) == 0);
      tick();
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL random t=%0d: got %h want %h", i, obs, expv);
      end
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; touch_key = '1; mode = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_momentary();
    test_simultaneous();
    test_reset_mid();
    test_mode_switch();
`ifdef TOUCH_LONG_PRESS_EN
    test_long_press();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
